// File: rtl/avalon_param_bank_if.sv
// Avalon-MM slave bus bundle for the parameter bank: word address, write strobe,
// byte lanes and zero-latency combinational readback.
interface avalon_param_bank_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write_n;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, write_n, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_param_bank.sv
// Multi-channel double-buffered parameter bank: CPU writes shadows, which are
// committed atomically to the fabric-facing active registers on frame sync or command.
module avalon_param_bank #(
  parameter int unsigned       NUM_CH    = 8,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_param_bank_if.slave       bus,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     update_pulse,
  output logic                     pending
);

  localparam int unsigned NumLanes = DATA_W / 8;

  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [DATA_W-1:0] active_q [NUM_CH];
  logic [DATA_W-1:0] active_d [NUM_CH];
  logic              auto_q, auto_d;
  logic              pending_q, pending_d;
  logic              missed_q, missed_d;
  logic              sync_q;
  logic              update_q;
  logic [15:0]       cnt_q, cnt_d;

  logic        bus_wr, shadow_wr, ctrl_wr, commit_now, sync_edge, commit;
  logic [31:0] wd32;
  logic [3:0]  be32;
  logic [31:0] rd32;

  // Zero-extend the bus so CTRL bits 8-9 decode uniformly for any DATA_W.
  assign wd32 = 32'(bus.writedata);
  assign be32 = 4'(bus.byteenable);

  assign bus_wr     = bus.chipselect & ~bus.write_n;
  assign shadow_wr  = bus_wr & (bus.address < ADDR_W'(NUM_CH));
  assign ctrl_wr    = bus_wr & (bus.address == ADDR_W'(NUM_CH));
  assign commit_now = ctrl_wr & be32[0] & wd32[1];
  assign sync_edge  = frame_sync & ~sync_q;
  assign commit     = (sync_edge & auto_q & pending_q) | commit_now;

  always_comb begin
    shadow_d = shadow_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (shadow_wr && bus.address == ADDR_W'(ch)) begin
        for (int b = 0; b < NumLanes; b++) begin
          if (bus.byteenable[b]) shadow_d[ch][b*8 +: 8] = bus.writedata[b*8 +: 8];
        end
      end
    end
  end

  // Active loads the pre-write shadow, so a colliding write stays staged.
  always_comb begin
    active_d = active_q;
    if (commit) active_d = shadow_q;
  end

  always_comb begin
    auto_d    = auto_q;
    pending_d = pending_q;
    missed_d  = missed_q;
    cnt_d     = cnt_q;
    if (ctrl_wr && be32[0]) auto_d = wd32[0];
    if (commit) begin
      pending_d = 1'b0;
      cnt_d     = cnt_q + 16'd1;
    end
    if (shadow_wr) pending_d = 1'b1;
    if (ctrl_wr && be32[1] && wd32[9]) missed_d = 1'b0;
    if (sync_edge && pending_q && !auto_q) missed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= RESET_VAL;
        active_q[ch] <= RESET_VAL;
      end
      auto_q    <= 1'b1;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
      sync_q    <= 1'b0;
      update_q  <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      auto_q    <= auto_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
      sync_q    <= frame_sync;
      update_q  <= commit;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    rd32 = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (bus.address == ADDR_W'(ch)) rd32 = 32'(shadow_q[ch]);
    end
    if (bus.address == ADDR_W'(NUM_CH)) begin
      rd32 = {22'd0, missed_q, pending_q, 7'd0, auto_q};
    end
    if (bus.address == ADDR_W'(NUM_CH + 1)) rd32 = {16'd0, cnt_q};
  end

  assign bus.readdata = rd32[DATA_W-1:0];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_out
    assign out_port[ch*DATA_W +: DATA_W] = active_q[ch];
  end

  assign update_pulse = update_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_avalon_param_bank.sv
// Directed self-checking bench for avalon_param_bank (8 x 32-bit, reset value 0x12345678).
module tb_avalon_param_bank;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] RV     = 32'h1234_5678;
  localparam logic [3:0]  A_CTRL = 4'd8;
  localparam logic [3:0]  A_CNT  = 4'd9;

  logic                     clk;
  logic                     reset;
  logic                     frame_sync;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic                     update_pulse;
  logic                     pending;

  int checks;
  int errors;

  avalon_param_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avalon_param_bank #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_VAL(RV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .frame_sync  (frame_sync),
    .out_port    (out_port),
    .update_pulse(update_pulse),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int i);
    return out_port[i*DATA_W +: DATA_W];
  endfunction

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Present a write for one cycle; optionally raise frame_sync in the same cycle.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic sync);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    if (sync) frame_sync = 1'b1;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic sync_rise();
    @(negedge clk);
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sync_fall();
    @(negedge clk);
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    frame_sync     = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.byteenable = '0;
    bus.writedata  = '0;
    #12;
    for (int i = 0; i < NUM_CH; i++) check($sformatf("reset_ch%0d", i), chan(i), RV);
    rd(A_CTRL, d); check("reset_ctrl", d, 32'h001);
    rd(A_CNT, d);  check("reset_cnt", d, 32'd0);
    check("reset_pending", {31'd0, pending}, 32'd0);
    check("reset_update", {31'd0, update_pulse}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Shadow staging with byte lanes 0 and 2.
    wr(4'd3, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    rd(4'd3, d);   check("stage_shadow3", d, 32'h12AD_56EF);
    check("stage_out3", chan(3), RV);
    check("stage_pending", {31'd0, pending}, 32'd1);
    rd(A_CTRL, d); check("stage_ctrl", d, 32'h101);
    sync_rise();
    check("auto_out3", chan(3), 32'h12AD_56EF);
    check("auto_update", {31'd0, update_pulse}, 32'd1);
    rd(A_CNT, d);  check("auto_cnt", d, 32'd1);
    check("auto_pending", {31'd0, pending}, 32'd0);
    sync_fall();
    check("auto_update_gone", {31'd0, update_pulse}, 32'd0);

    // Manual mode: edge with pending flags MISSED instead of committing.
    wr(A_CTRL, 32'h0, 4'b0011, 1'b0);
    wr(4'd0, 32'd5, 4'b1111, 1'b0);
    sync_rise();
    check("manual_out0", chan(0), RV);
    check("manual_update", {31'd0, update_pulse}, 32'd0);
    rd(A_CTRL, d); check("manual_ctrl", d, 32'h300);
    sync_fall();
    wr(A_CTRL, 32'h202, 4'b0011, 1'b0);
    check("cmd_out0", chan(0), 32'd5);
    check("cmd_update", {31'd0, update_pulse}, 32'd1);
    rd(A_CTRL, d); check("cmd_ctrl", d, 32'h000);
    rd(A_CNT, d);  check("cmd_cnt", d, 32'd2);

    // Collision: write and committing edge in the same cycle.
    wr(A_CTRL, 32'h1, 4'b0001, 1'b0);
    wr(4'd1, 32'h9, 4'b1111, 1'b0);
    wr(4'd1, 32'hA, 4'b1111, 1'b1);
    check("coll_out1", chan(1), 32'h9);
    rd(4'd1, d);   check("coll_shadow1", d, 32'hA);
    check("coll_pending", {31'd0, pending}, 32'd1);
    rd(A_CNT, d);  check("coll_cnt", d, 32'd3);
    sync_fall();
    sync_rise();
    check("coll_next_out1", chan(1), 32'hA);
    rd(A_CNT, d);  check("coll_next_cnt", d, 32'd4);
    sync_fall();

    // Held-high sync and idle edges never count.
    sync_rise();
    check("idle_update", {31'd0, update_pulse}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rd(A_CNT, d);  check("idle_cnt", d, 32'd4);
    sync_fall();

    // COMMIT_NOW together with a committing edge counts once.
    wr(4'd4, 32'h44, 4'b1111, 1'b0);
    wr(A_CTRL, 32'h3, 4'b0001, 1'b1);
    check("dual_out4", chan(4), 32'h44);
    rd(A_CNT, d);  check("dual_cnt", d, 32'd5);
    sync_fall();

    // Counter wrap via back-to-back COMMIT_NOW writes.
    @(negedge clk);
    bus.address    = A_CTRL;
    bus.writedata  = 32'h3;
    bus.byteenable = 4'b0001;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    repeat (65535 - 5) @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    rd(A_CNT, d);  check("wrap_max", d, 32'hFFFF);
    wr(A_CTRL, 32'h3, 4'b0001, 1'b0);
    rd(A_CNT, d);  check("wrap_zero", d, 32'd0);

    // Async reset mid-cycle while pending.
    wr(4'd2, 32'h77, 4'b1111, 1'b0);
    check("prereset_pending", {31'd0, pending}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out2", chan(2), RV);
    check("areset_out4", chan(4), RV);
    check("areset_pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd(A_CTRL, d); check("postreset_ctrl", d, 32'h001);
    rd(A_CNT, d);  check("postreset_cnt", d, 32'd0);
    rd(4'd2, d);   check("postreset_shadow2", d, RV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
